dmem_responder: RTL and testbench

//  Handshaked data-memory responder: target end of the core's load/store interface.

---
 rtl/dmem_responder.sv | 138 +++++++++++++
 tb/tb_dmem_responder.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// ============================================================================
// Module      : dmem_responder
// Description : Handshaked data-memory responder. It accepts one load or store
//               at a time, waits LATENCY cycles, then performs the word access
//               and presents the response until the requester takes it.
//               Optional macro DMEM_MISALIGN_CHECK_EN rejects requests with
//               req_addr[1:0] != 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_responder #(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int         c_AW  = $clog2(DEPTH);
    localparam logic [3:0] c_LAT = 4'(LATENCY);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [3:0]      r_cnt;
    logic            r_we;
    logic [31:0]     r_addr;
    logic [31:0]     r_wdata;
    logic [3:0]      r_be;
    logic [31:0]     r_rdata;
    logic            r_err;
    logic [31:0]     r_mem [DEPTH];

    logic            w_accept;
    logic            w_access;
    logic [c_AW-1:0] w_idx;
    logic            w_range_err;
    logic            w_mis_err;
    logic            w_err;

    assign w_accept    = (r_state == S_IDLE) && req_valid;
    assign w_access    = (r_state == S_WAIT) && (r_cnt == 4'd0);
    assign w_idx       = r_addr[c_AW+1:2];
    assign w_range_err = |r_addr[31:c_AW+2];

`ifdef DMEM_MISALIGN_CHECK_EN
    assign w_mis_err = |r_addr[1:0];
`else
    logic w_unused_addr_lo;
    assign w_unused_addr_lo = ^r_addr[1:0];
    assign w_mis_err        = 1'b0;
`endif

    assign w_err = w_mis_err | w_range_err;

    assign req_ready = (r_state == S_IDLE);
    assign rsp_valid = (r_state == S_RESP);
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (req_valid) w_state_nxt = S_WAIT;
            S_WAIT:  if (r_cnt == 4'd0) w_state_nxt = S_RESP;
            S_RESP:  if (rsp_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt   <= 4'd0;
            r_we    <= 1'b0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_be    <= 4'd0;
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_we    <= req_we;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                r_be    <= req_be;
                r_cnt   <= c_LAT;
            end else if (r_state == S_WAIT && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end

            if (w_access) begin
                r_rdata <= (r_we || w_err) ? 32'd0 : r_mem[w_idx];
                r_err   <= w_err;
            end else if (r_state == S_RESP && rsp_ready) begin
                r_rdata <= 32'd0;
                r_err   <= 1'b0;
            end
        end
    end

    // RAM is not reset; reset forces IDLE, so an interrupted access never writes.
    always_ff @(posedge clk) begin
        if (w_access && r_we && !w_err) begin
            for (int i = 0; i < 4; i++) begin
                if (r_be[i]) begin
                    r_mem[w_idx][8*i +: 8] <= r_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
// ============================================================================
// Module      : tb_dmem_responder
// Description : Table-driven bench for dmem_responder (DEPTH=64, LATENCY=2),
//               plus a LATENCY=0 instance for the single-cycle wait case.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_responder;

    localparam int c_LAT = 2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid, req_we, rsp_ready;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_be;
    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;

    logic        z_req_valid, z_req_we, z_rsp_ready;
    logic [31:0] z_req_addr, z_req_wdata;
    logic [3:0]  z_req_be;
    logic        z_req_ready, z_rsp_valid, z_rsp_err;
    logic [31:0] z_rsp_rdata;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(64), .LATENCY(c_LAT)) u_dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    dmem_responder #(.DEPTH(64), .LATENCY(0)) u_dut0 (
        .clk(clk), .reset_n(reset_n),
        .req_valid(z_req_valid), .req_ready(z_req_ready), .req_we(z_req_we),
        .req_addr(z_req_addr), .req_wdata(z_req_wdata), .req_be(z_req_be),
        .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready),
        .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Ends on the negedge just after the accept edge, with req_valid dropped.
    task automatic send(input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be);
        @(negedge clk);
        chk("req_ready_before_send", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic recv(input string name, input logic [31:0] exp_rdata, input logic exp_err);
        int n;
        n = 0;
        while (!rsp_valid && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk({name, "_latency"}, n, c_LAT + 1);
        chk({name, "_rdata"}, rsp_rdata, exp_rdata);
        chk({name, "_err"}, {31'd0, rsp_err}, {31'd0, exp_err});
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk({name, "_valid_drop"}, {31'd0, rsp_valid}, 32'd0);
        chk({name, "_rdata_clr"}, rsp_rdata, 32'd0);
    endtask

    function automatic vec_t mk(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [3:0] be, input logic [31:0] er, input logic ee);
        vec_t v;
        v.we = we; v.addr = addr; v.wdata = wdata; v.be = be;
        v.exp_rdata = er; v.exp_err = ee;
        return v;
    endfunction

    initial begin
        logic [31:0] exp100;
        logic        mis_err;
        int          n;
`ifdef DMEM_MISALIGN_CHECK_EN
        mis_err = 1'b1;
        exp100  = 32'd25;
`else
        mis_err = 1'b0;
        exp100  = 32'hCAFEF00D;
`endif
        vecs[0]  = mk(1'b1, 32'd100, 32'd25,         4'hF, 32'd0,         1'b0);
        vecs[1]  = mk(1'b0, 32'd100, 32'd0,          4'h0, 32'd25,        1'b0);
        vecs[2]  = mk(1'b1, 32'd8,   32'hAABBCCDD,   4'hF, 32'd0,         1'b0);
        vecs[3]  = mk(1'b1, 32'd8,   32'h11223344,   4'h5, 32'd0,         1'b0);
        vecs[4]  = mk(1'b0, 32'd8,   32'd0,          4'hF, 32'hAA22CC44,  1'b0);
        vecs[5]  = mk(1'b1, 32'd0,   32'h12345678,   4'hF, 32'd0,         1'b0);
        vecs[6]  = mk(1'b1, 32'd256, 32'hDEADBEEF,   4'hF, 32'd0,         1'b1);
        vecs[7]  = mk(1'b0, 32'd256, 32'd0,          4'hF, 32'd0,         1'b1);
        vecs[8]  = mk(1'b0, 32'd0,   32'd0,          4'h0, 32'h12345678,  1'b0);
        vecs[9]  = mk(1'b1, 32'd8,   32'h0,          4'h0, 32'd0,         1'b0);
        vecs[10] = mk(1'b0, 32'd8,   32'd0,          4'h0, 32'hAA22CC44,  1'b0);
        vecs[11] = mk(1'b1, 32'd102, 32'hCAFEF00D,   4'hF, 32'd0,         mis_err);
        vecs[12] = mk(1'b1, 32'd12,  32'h0BADF00D,   4'hF, 32'd0,         1'b0);
        vecs[13] = mk(1'b0, 32'h8000_0000, 32'd0,    4'hF, 32'd0,         1'b1);

        reset_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0;
        req_wdata = 32'd0; req_be = 4'd0; rsp_ready = 1'b0;
        z_req_valid = 1'b0; z_req_we = 1'b0; z_req_addr = 32'd0;
        z_req_wdata = 32'd0; z_req_be = 4'd0; z_rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_err",   {31'd0, rsp_err}, 32'd0);
        reset_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            send(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be);
            recv($sformatf("vec%0d", i), vecs[i].exp_rdata, vecs[i].exp_err);
        end

        // Load @100 stalled by rsp_ready low; a second request waits behind it.
        send(1'b0, 32'd100, 32'd0, 4'h0);
        n = 0;
        while (!rsp_valid && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk("stall_latency", n, c_LAT + 1);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'd8; req_be = 4'h0;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("stall_valid%0d", k), {31'd0, rsp_valid}, 32'd1);
            chk($sformatf("stall_rdata%0d", k), rsp_rdata, exp100);
            chk($sformatf("stall_req_ready%0d", k), {31'd0, req_ready}, 32'd0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("stall_release_ready", {31'd0, req_ready}, 32'd1);
        chk("stall_release_valid", {31'd0, rsp_valid}, 32'd0);
        @(negedge clk);
        req_valid = 1'b0;
        chk("stall_next_accepted", {31'd0, req_ready}, 32'd0);
        recv("stall_next", 32'hAA22CC44, 1'b0);

        // Reset during WAIT of a store must drop the write.
        send(1'b1, 32'd12, 32'h55, 4'hF);
        reset_n = 1'b0;
        #1;
        chk("midrst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("midrst_rsp_rdata", rsp_rdata, 32'd0);
        chk("midrst_rsp_err",   {31'd0, rsp_err}, 32'd0);
        repeat (4) @(negedge clk);
        reset_n = 1'b1;
        send(1'b0, 32'd12, 32'd0, 4'h0);
        recv("midrst_load", 32'h0BADF00D, 1'b0);

        // LATENCY=0 instance: response one cycle after accept.
        for (int j = 0; j < 2; j++) begin
            @(negedge clk);
            z_req_valid = 1'b1; z_req_we = (j == 0); z_req_addr = 32'd4;
            z_req_wdata = 32'h77; z_req_be = 4'hF;
            @(negedge clk);
            z_req_valid = 1'b0;
            chk($sformatf("lat0_wait%0d", j), {31'd0, z_rsp_valid}, 32'd0);
            @(negedge clk);
            chk($sformatf("lat0_valid%0d", j), {31'd0, z_rsp_valid}, 32'd1);
            chk($sformatf("lat0_rdata%0d", j), z_rsp_rdata, (j == 0) ? 32'd0 : 32'h77);
            z_rsp_ready = 1'b1;
            @(negedge clk);
            z_rsp_ready = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
